// File: rtl/bnn_conv_ctrl.sv
// Window scheduler for the binary convolution datapath: fetches each KxK window from pixel SRAM,
// presents it to the external conv unit and streams the registered sum. Optional ReLU: CONV_CTRL_RELU_EN.
module bnn_conv_ctrl #(
    parameter int DATA_WIDTH = 4,
    parameter int K          = 4,
    parameter int LOGK       = 4,
    parameter int IMG_W      = 8,
    parameter int IMG_H      = 8,
    parameter int ADDR_W     = 6
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         start,
    input  logic                         w_load,
    input  logic [K*K-1:0]               w_data,
    output logic                         fm_ren,
    output logic [ADDR_W-1:0]            fm_addr,
    input  logic [DATA_WIDTH-1:0]        fm_rdata,
    output logic [K*K*DATA_WIDTH-1:0]    win_data,
    output logic [K*K-1:0]               weight,
    input  logic [DATA_WIDTH+LOGK-1:0]   conv_sum,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [DATA_WIDTH+LOGK-1:0]   out_data,
    output logic                         busy,
    output logic                         done,
    output logic [2:0]                   dbg_state
);

    localparam int NT    = K * K;
    localparam int TAP_W = (NT > 1) ? $clog2(NT) : 1;
    localparam int KW    = (K > 1) ? $clog2(K) : 1;
    localparam int SW    = DATA_WIDTH + LOGK;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FETCH = 3'd1,
        S_WAIT  = 3'd2,
        S_CALC  = 3'd3,
        S_EMIT  = 3'd4
    } state_t;

    state_t                    state_q;
    logic [ADDR_W-1:0]         oy_q, ox_q;
    logic [KW-1:0]             ky_q, kx_q;
    logic [TAP_W-1:0]          tap_q, rd_tap_q;
    logic                      rd_valid_q;
    logic                      fm_ren_q;
    logic [ADDR_W-1:0]         fm_addr_q;
    logic [NT*DATA_WIDTH-1:0]  win_q;
    logic [NT-1:0]             weight_q;
    logic                      out_valid_q;
    logic [SW-1:0]             out_data_q;
    logic                      busy_q;
    logic                      done_q;

    logic [KW-1:0]             nkx_d, nky_d;
    logic [ADDR_W-1:0]         nox_d, noy_d;
    logic                      last_ox, last_oy;

    function automatic logic [ADDR_W-1:0] pix_addr(input logic [ADDR_W-1:0] y,
                                                   input logic [ADDR_W-1:0] x,
                                                   input logic [KW-1:0]     dy,
                                                   input logic [KW-1:0]     dx);
        return (y + ADDR_W'(dy)) * ADDR_W'(IMG_W) + x + ADDR_W'(dx);
    endfunction

    always_comb begin
        nkx_d   = (kx_q == KW'(K - 1)) ? '0 : kx_q + KW'(1);
        nky_d   = (kx_q == KW'(K - 1)) ? ky_q + KW'(1) : ky_q;
        last_ox = (ox_q == ADDR_W'(IMG_W - K));
        last_oy = (oy_q == ADDR_W'(IMG_H - K));
        nox_d   = last_ox ? '0 : ox_q + ADDR_W'(1);
        noy_d   = last_ox ? oy_q + ADDR_W'(1) : oy_q;
    end

    // Output stream: out_valid stays high with out_data and win_data frozen until a cycle
    // with out_valid && out_ready; that cycle is the transfer and the next fetch starts after it.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            oy_q        <= '0;
            ox_q        <= '0;
            ky_q        <= '0;
            kx_q        <= '0;
            tap_q       <= '0;
            rd_tap_q    <= '0;
            rd_valid_q  <= 1'b0;
            fm_ren_q    <= 1'b0;
            fm_addr_q   <= '0;
            win_q       <= '0;
            weight_q    <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            rd_valid_q <= 1'b0;
            done_q     <= 1'b0;
            // SRAM data lags the address by one cycle, so it lands in the previous tap's slot.
            if (rd_valid_q) begin
                win_q[int'(rd_tap_q)*DATA_WIDTH +: DATA_WIDTH] <= fm_rdata;
            end
            case (state_q)
                S_IDLE: begin
                    if (w_load) begin
                        weight_q <= w_data;
                    end
                    if (start) begin
                        state_q   <= S_FETCH;
                        busy_q    <= 1'b1;
                        oy_q      <= '0;
                        ox_q      <= '0;
                        ky_q      <= '0;
                        kx_q      <= '0;
                        tap_q     <= '0;
                        fm_ren_q  <= 1'b1;
                        fm_addr_q <= '0;
                    end
                end
                S_FETCH: begin
                    rd_valid_q <= 1'b1;
                    rd_tap_q   <= tap_q;
                    if (tap_q == TAP_W'(NT - 1)) begin
                        state_q  <= S_WAIT;
                        fm_ren_q <= 1'b0;
                    end else begin
                        tap_q     <= tap_q + TAP_W'(1);
                        kx_q      <= nkx_d;
                        ky_q      <= nky_d;
                        fm_addr_q <= pix_addr(oy_q, ox_q, nky_d, nkx_d);
                    end
                end
                S_WAIT: begin
                    state_q <= S_CALC;
                end
                S_CALC: begin
`ifdef CONV_CTRL_RELU_EN
                    out_data_q <= conv_sum[SW-1] ? '0 : conv_sum;
`else
                    out_data_q <= conv_sum;
`endif
                    out_valid_q <= 1'b1;
                    state_q     <= S_EMIT;
                end
                S_EMIT: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        if (last_ox && last_oy) begin
                            state_q <= S_IDLE;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                        end else begin
                            state_q   <= S_FETCH;
                            ox_q      <= nox_d;
                            oy_q      <= noy_d;
                            ky_q      <= '0;
                            kx_q      <= '0;
                            tap_q     <= '0;
                            fm_ren_q  <= 1'b1;
                            fm_addr_q <= pix_addr(noy_d, nox_d, '0, '0);
                        end
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign fm_ren    = fm_ren_q;
    assign fm_addr   = fm_addr_q;
    assign win_data  = win_q;
    assign weight    = weight_q;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_bnn_conv_ctrl.sv
// Bench for bnn_conv_ctrl: SRAM and conv-unit models, a window-level reference model feeding
// expected queues, a negedge monitor for addresses/results/timing, and directed passes.
module tb_bnn_conv_ctrl;

    localparam int DW   = 4;
    localparam int K    = 4;
    localparam int LOGK = 4;
    localparam int IW   = 8;
    localparam int IH   = 8;
    localparam int AW   = 6;
    localparam int NT   = K * K;
    localparam int SW   = DW + LOGK;
    localparam int NWIN = (IH - K + 1) * (IW - K + 1);
    localparam int WIN_PERIOD = NT + 3;
`ifdef CONV_CTRL_RELU_EN
    localparam logic [SW-1:0] ZERO_W_RES = 8'h00;
`else
    localparam logic [SW-1:0] ZERO_W_RES = 8'hF0;
`endif

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic               start = 1'b0;
    logic               w_load = 1'b0;
    logic [NT-1:0]      w_data = '0;
    logic               fm_ren;
    logic [AW-1:0]      fm_addr;
    logic [DW-1:0]      fm_rdata;
    logic [NT*DW-1:0]   win_data;
    logic [NT-1:0]      weight;
    logic [SW-1:0]      conv_sum;
    logic               out_valid;
    logic               out_ready = 1'b0;
    logic [SW-1:0]      out_data;
    logic               busy;
    logic               done;
    logic [2:0]         dbg_state;

    bnn_conv_ctrl #(
        .DATA_WIDTH(DW), .K(K), .LOGK(LOGK), .IMG_W(IW), .IMG_H(IH), .ADDR_W(AW)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .w_load(w_load), .w_data(w_data),
        .fm_ren(fm_ren), .fm_addr(fm_addr), .fm_rdata(fm_rdata),
        .win_data(win_data), .weight(weight), .conv_sum(conv_sum),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .busy(busy), .done(done), .dbg_state(dbg_state)
    );

    // clock / environment models
    always #5 clk = ~clk;

    logic [DW-1:0] mem [IW*IH];
    always @(posedge clk) begin
        if (fm_ren) fm_rdata <= mem[fm_addr];
    end

    function automatic logic [SW-1:0] conv_unit(input logic [NT*DW-1:0] win, input logic [NT-1:0] w);
        int s;
        logic signed [DW-1:0] p;
        s = 0;
        for (int j = 0; j < NT; j++) begin
            p = win[j*DW +: DW];
            s = w[j] ? s + int'(p) : s - int'(p);
        end
        return SW'(s);
    endfunction

    always_comb conv_sum = conv_unit(win_data, weight);

    // scoreboard state
    logic [SW-1:0] exp_q[$];
    logic [AW-1:0] addr_q[$];
    int  checks = 0;
    int  errors = 0;
    int  cyc = 0;
    int  res_cnt = 0;
    int  done_cnt = 0;
    int  stall_cnt = 0;
    int  gap_extra = 0;
    int  last_rise = 0;
    int  first_rise = 0;
    bit  first_pend = 0;
    bit  have_rise = 0;
    bit  prev_valid = 0;
    bit  done_exp = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int pixel(input int r, input int c);
        logic signed [DW-1:0] v;
        v = mem[r*IW + c];
        return int'(v);
    endfunction

    // Reference: every output window of the map in row-major order, stride 1, no padding.
    task automatic load_model(input logic [NT-1:0] w);
        int s;
        logic [SW-1:0] r;
        for (int oy = 0; oy <= IH - K; oy++) begin
            for (int ox = 0; ox <= IW - K; ox++) begin
                s = 0;
                for (int ky = 0; ky < K; ky++) begin
                    for (int kx = 0; kx < K; kx++) begin
                        s = w[ky*K + kx] ? s + pixel(oy + ky, ox + kx) : s - pixel(oy + ky, ox + kx);
                        addr_q.push_back(AW'((oy + ky) * IW + ox + kx));
                    end
                end
                r = SW'(s);
`ifdef CONV_CTRL_RELU_EN
                if (r[SW-1]) r = '0;
`endif
                exp_q.push_back(r);
            end
        end
    endtask

    // monitor: samples 1 time unit after the negedge, after the driver has updated inputs
    always @(negedge clk) begin
        #1;
        cyc++;
        if (!rst_n) begin
            res_cnt = 0; first_pend = 0; have_rise = 0; prev_valid = 0; done_exp = 0; stall_cnt = 0;
        end else begin
            if (done || done_exp) begin
                check("done_pulse", done, done_exp);
                if (done) begin
                    done_cnt++;
                    check("busy_at_done", busy, 0);
                end
            end
            done_exp = 0;
            if (start && !busy) begin
                first_pend = 1; have_rise = 0; first_rise = cyc + WIN_PERIOD; res_cnt = 0; stall_cnt = 0;
            end
            if (fm_ren) begin
                if (addr_q.size() == 0) check("fetch_extra", 1, 0);
                else check("fetch_addr", fm_addr, addr_q.pop_front());
            end
            if (out_valid && !prev_valid) begin
                if (first_pend) begin
                    check("first_valid_cycle", cyc, first_rise);
                    first_pend = 0;
                    have_rise = 1;
                end else if (have_rise) begin
                    check("valid_gap", cyc - last_rise, WIN_PERIOD + gap_extra);
                end
                last_rise = cyc;
            end
            if (out_valid && !out_ready) stall_cnt++;
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) check("result_extra", 1, 0);
                else check("out_data", out_data, exp_q.pop_front());
                gap_extra = stall_cnt;
                stall_cnt = 0;
                res_cnt++;
                if (res_cnt == NWIN) begin
                    done_exp = 1;
                    have_rise = 0;
                end
            end
            prev_valid = out_valid;
        end
    end

    // driver tasks (all called at a negedge)
    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic fill_pixels(input bit rnd);
        for (int i = 0; i < IW*IH; i++) mem[i] = rnd ? DW'($urandom_range(0, 15)) : DW'(1);
    endtask

    task automatic load_weights(input logic [NT-1:0] w);
        w_load = 1'b1; w_data = w;
        tick(1);
        w_load = 1'b0;
    endtask

    task automatic pulse_start(input bit ld, input logic [NT-1:0] w);
        start = 1'b1; w_load = ld; w_data = w;
        tick(1);
        start = 1'b0; w_load = 1'b0;
    endtask

    task automatic check_reset_vals(input string pfx);
        check({pfx, "_fm_ren"}, fm_ren, 0);
        check({pfx, "_fm_addr"}, fm_addr, 0);
        check({pfx, "_win_data"}, win_data, 0);
        check({pfx, "_weight"}, weight, 0);
        check({pfx, "_out_valid"}, out_valid, 0);
        check({pfx, "_out_data"}, out_data, 0);
        check({pfx, "_busy"}, busy, 0);
        check({pfx, "_done"}, done, 0);
    endtask

    task automatic wait_valid(input int budget);
        int n;
        n = 0;
        while (!out_valid && n < budget) begin
            tick(1);
            n++;
        end
        check("valid_timeout", out_valid, 1);
    endtask

    task automatic wait_pass(input bit rand_ready, input int budget);
        int d0;
        int n;
        d0 = done_cnt;
        n = 0;
        while (done_cnt == d0 && n < budget) begin
            out_ready = rand_ready ? ($urandom_range(0, 3) != 0) : 1'b1;
            tick(1);
            n++;
        end
        out_ready = 1'b1;
        check("pass_done", done_cnt != d0, 1);
        check("results_drained", exp_q.size(), 0);
        check("fetches_drained", addr_q.size(), 0);
    endtask

    initial begin
        logic [NT-1:0]    w;
        logic [SW-1:0]    held_out;
        logic [NT*DW-1:0] held_win;
        int d0;
        int n;

        // reset
        rst_n = 1'b0;
        tick(3);
        check_reset_vals("reset");
        rst_n = 1'b1;
        tick(1);

        // all-ones map, all +1 weights, cycle-accurate first window
        fill_pixels(0);
        load_weights(16'hFFFF);
        check("weight_load", weight, 16'hFFFF);
        load_model(16'hFFFF);
        out_ready = 1'b1;
        pulse_start(0, '0);
        for (int i = 1; i <= WIN_PERIOD; i++) begin
            if (i > 1) tick(1);
            check("fetch_ren_window0", fm_ren, i <= NT);
            check("out_valid_window0", out_valid, i == WIN_PERIOD);
            if (i == WIN_PERIOD) check("all_ones_result", out_data, 8'h10);
        end
        wait_pass(0, 1000);

        // all -1 weights, loaded in the same cycle as start
        load_model(16'h0000);
        pulse_start(1, 16'h0000);
        check("weight_with_start", weight, 16'h0000);
        wait_valid(100);
        check("zero_weight_result", out_data, ZERO_W_RES);
        wait_pass(0, 1000);

        // random map/kernel, 10-cycle stall, ignored start/w_load mid-pass, random backpressure
        fill_pixels(1);
        w = NT'($urandom);
        load_weights(w);
        load_model(w);
        pulse_start(0, '0);
        wait_valid(100);
        out_ready = 1'b0;
        held_out = out_data;
        held_win = win_data;
        for (int i = 0; i < 10; i++) begin
            check("stall_out_data", out_data, held_out);
            check("stall_win_data", win_data, held_win);
            check("stall_no_fetch", fm_ren, 0);
            check("stall_valid", out_valid, 1);
            tick(1);
        end
        out_ready = 1'b1;
        tick(25);
        start = 1'b1; w_load = 1'b1; w_data = ~w;
        tick(1);
        start = 1'b0; w_load = 1'b0;
        check("weight_frozen", weight, w);
        check("busy_mid_pass", busy, 1);
        wait_pass(1, 3000);

        // reset during fetch of window 7, then a full clean pass
        fill_pixels(1);
        w = NT'($urandom);
        load_weights(w);
        load_model(w);
        pulse_start(0, '0);
        n = 0;
        while (!(res_cnt == 7 && fm_ren) && n < 500) begin
            tick(1);
            n++;
        end
        check("reached_window7", res_cnt, 7);
        tick(2);
        rst_n = 1'b0;
        tick(1);
        rst_n = 1'b1;
        exp_q.delete();
        addr_q.delete();
        check_reset_vals("midpass_reset");
        d0 = done_cnt;
        tick(40);
        check("no_done_after_reset", done_cnt, d0);
        check("idle_after_reset", busy, 0);
        load_weights(w);
        load_model(w);
        pulse_start(0, '0);
        wait_pass(1, 3000);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, errors=%0d checks=%0d", errors, checks);
        $fatal(1, "watchdog");
    end

endmodule
